// File: rtl/exec_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_seq
// Desc     : ARM execute stage with NZCV register and 16 data-processing ops;
//            the iterative shift-add MUL is compiled in with EXEC_ALU_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module exec_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             sh_carry,
    input  logic [3:0]       alu_op,
    input  logic             is_mul,
    input  logic             set_flags,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_EOR = 4'b0001;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_RSB = 4'b0011;
    localparam logic [3:0] c_OP_ADD = 4'b0100;
    localparam logic [3:0] c_OP_ADC = 4'b0101;
    localparam logic [3:0] c_OP_SBC = 4'b0110;
    localparam logic [3:0] c_OP_RSC = 4'b0111;
    localparam logic [3:0] c_OP_TST = 4'b1000;
    localparam logic [3:0] c_OP_TEQ = 4'b1001;
    localparam logic [3:0] c_OP_CMP = 4'b1010;
    localparam logic [3:0] c_OP_CMN = 4'b1011;
    localparam logic [3:0] c_OP_ORR = 4'b1100;
    localparam logic [3:0] c_OP_MOV = 4'b1101;
    localparam logic [3:0] c_OP_BIC = 4'b1110;
    localparam logic [3:0] c_OP_MVN = 4'b1111;

`ifdef EXEC_ALU_MUL_EN
    localparam int                c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_MUL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`endif

    state_t             r_state, w_state_nxt;
    logic               r_out_valid, w_valid_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_wr_en, w_wr_en_nxt;
    logic [3:0]         r_flags, w_flags_nxt;

    logic               w_accept;
    logic               w_logic;
    logic [WIDTH-1:0]   w_lres, w_x, w_y, w_alu_res;
    logic               w_cin, w_alu_c, w_alu_v;
    logic [WIDTH:0]     w_sum;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign wr_en     = r_wr_en;
    assign flags     = r_flags;
    assign w_accept  = in_valid && in_ready;

    // Single 33-bit adder; reverse forms swap operands, subtracts invert B.
    always_comb begin
        w_logic = 1'b1;
        w_lres  = '0;
        w_x     = srca;
        w_y     = ~srcb;
        w_cin   = 1'b1;
        case (alu_op)
            c_OP_AND, c_OP_TST: w_lres = srca & srcb;
            c_OP_EOR, c_OP_TEQ: w_lres = srca ^ srcb;
            c_OP_ORR:           w_lres = srca | srcb;
            c_OP_MOV:           w_lres = srcb;
            c_OP_BIC:           w_lres = srca & ~srcb;
            c_OP_MVN:           w_lres = ~srcb;
            c_OP_SUB, c_OP_CMP: w_logic = 1'b0;
            c_OP_RSB: begin
                w_logic = 1'b0;
                w_x     = srcb;
                w_y     = ~srca;
            end
            c_OP_ADD, c_OP_CMN: begin
                w_logic = 1'b0;
                w_y     = srcb;
                w_cin   = 1'b0;
            end
            c_OP_ADC: begin
                w_logic = 1'b0;
                w_y     = srcb;
                w_cin   = r_flags[1];
            end
            c_OP_SBC: begin
                w_logic = 1'b0;
                w_cin   = r_flags[1];
            end
            c_OP_RSC: begin
                w_logic = 1'b0;
                w_x     = srcb;
                w_y     = ~srca;
                w_cin   = r_flags[1];
            end
            default: w_logic = 1'b1;
        endcase
    end

    assign w_sum     = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    assign w_alu_res = w_logic ? w_lres : w_sum[WIDTH-1:0];
    assign w_alu_c   = w_logic ? sh_carry : w_sum[WIDTH];
    assign w_alu_v   = w_logic ? r_flags[0]
                     : ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]));

`ifdef EXEC_ALU_MUL_EN
    logic [WIDTH-1:0]   r_ma, r_mb, r_acc, w_mul_sum;
    logic [c_CW-1:0]    r_count;
    logic               r_mul_s;

    assign w_mul_sum = r_acc + (r_mb[0] ? r_ma : '0);
    assign busy      = (r_state == S_MUL);
    assign in_ready  = (r_state != S_MUL);

    // Multiplicand shifts left, multiplier shifts right: one bit per cycle, LSB first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ma    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_mul_s <= 1'b0;
        end else if (r_state == S_MUL) begin
            r_acc   <= w_mul_sum;
            r_ma    <= r_ma << 1;
            r_mb    <= r_mb >> 1;
            r_count <= r_count + 1'b1;
        end else if (w_accept && is_mul) begin
            r_ma    <= srca;
            r_mb    <= srcb;
            r_acc   <= '0;
            r_count <= '0;
            r_mul_s <= set_flags;
        end
    end
`else
    assign busy     = 1'b0;
    assign in_ready = 1'b1;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = 1'b0;
        w_result_nxt = r_result;
        w_wr_en_nxt  = r_wr_en;
        w_flags_nxt  = r_flags;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept && is_mul) begin
`ifdef EXEC_ALU_MUL_EN
                    w_state_nxt  = S_MUL;
`else
                    w_state_nxt  = S_DONE;
                    w_valid_nxt  = 1'b1;
                    w_result_nxt = '0;
                    w_wr_en_nxt  = 1'b0;
`endif
                end else if (w_accept) begin
                    w_state_nxt  = S_DONE;
                    w_valid_nxt  = 1'b1;
                    w_result_nxt = w_alu_res;
                    w_wr_en_nxt  = (alu_op[3:2] != 2'b10);
                    if (set_flags || (alu_op[3:2] == 2'b10)) begin
                        w_flags_nxt = {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v};
                    end
                end else if (r_state == S_DONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef EXEC_ALU_MUL_EN
            S_MUL: begin
                if (r_count == c_LAST) begin
                    w_state_nxt  = S_DONE;
                    w_valid_nxt  = 1'b1;
                    w_result_nxt = w_mul_sum;
                    w_wr_en_nxt  = 1'b1;
                    if (r_mul_s) begin
                        w_flags_nxt = {w_mul_sum[WIDTH-1], (w_mul_sum == '0), r_flags[1:0]};
                    end
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_wr_en     <= 1'b0;
            r_flags     <= 4'b0000;
        end else begin
            r_out_valid <= w_valid_nxt;
            r_result    <= w_result_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_flags     <= w_flags_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_alu_seq.sv
`default_nettype none
// Testbench for exec_alu_seq: directed and random ops predicted by an
// arithmetic reference model, checked by a scoreboard monitor.
module tb_exec_alu_seq;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, sh_carry, is_mul, set_flags;
    logic [31:0] srca, srcb, result;
    logic [3:0]  alu_op, flags;
    logic        out_valid, wr_en, busy;

    always #5 clk = ~clk;

    exec_alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .srca(srca), .srcb(srcb), .sh_carry(sh_carry), .alu_op(alu_op),
        .is_mul(is_mul), .set_flags(set_flags), .out_valid(out_valid),
        .result(result), .wr_en(wr_en), .flags(flags), .busy(busy)
    );

    typedef struct {
        logic [31:0] res;
        logic        we;
        logic [3:0]  nzcv;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [3:0]  m_flags = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Exact integer arithmetic: returns {C, V, result}.
    function automatic logic [33:0] arith(input logic [31:0] x, input logic [31:0] y,
                                          input bit sub, input bit ci);
        longint unsigned ux = {32'b0, x};
        longint unsigned uy = {32'b0, y};
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned brw = {63'b0, ~ci};
        longint unsigned ur;
        longint          sr;
        bit              c, v;
        if (sub) begin
            ur = ux - uy - brw;
            c  = (ux >= uy + brw);
            sr = sx - sy - longint'(brw);
        end else begin
            ur = ux + uy + {63'b0, ci};
            c  = ((ur >> 32) != 0);
            sr = sx + sy + longint'({63'b0, ci});
        end
        v = (sr != longint'($signed(ur[31:0])));
        return {c, v, ur[31:0]};
    endfunction

    task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic shc, input logic s, input logic mul);
        exp_t        e;
        logic [33:0] ar;
        logic [31:0] r;
        logic        lg, c, v;
`ifdef EXEC_ALU_MUL_EN
        longint unsigned prod;
`endif
        e.due = cyc + 1;
        if (mul) begin
`ifdef EXEC_ALU_MUL_EN
            prod  = {32'b0, a} * {32'b0, b};
            r     = prod[31:0];
            e.due = cyc + 33;
            e.res = r;
            e.we  = 1'b1;
            if (s) m_flags[3:2] = {r[31], (r == 32'b0)};
`else
            e.res = 32'b0;
            e.we  = 1'b0;
`endif
        end else begin
            lg = op inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF};
            r  = 32'b0;
            ar = 34'b0;
            case (op)
                4'h0, 4'h8: r = a & b;
                4'h1, 4'h9: r = a ^ b;
                4'hC:       r = a | b;
                4'hD:       r = b;
                4'hE:       r = a & ~b;
                4'hF:       r = ~b;
                4'h2, 4'hA: ar = arith(a, b, 1'b1, 1'b1);
                4'h3:       ar = arith(b, a, 1'b1, 1'b1);
                4'h4, 4'hB: ar = arith(a, b, 1'b0, 1'b0);
                4'h5:       ar = arith(a, b, 1'b0, m_flags[1]);
                4'h6:       ar = arith(a, b, 1'b1, m_flags[1]);
                default:    ar = arith(b, a, 1'b1, m_flags[1]);
            endcase
            if (lg) begin
                c = shc;
                v = m_flags[0];
            end else begin
                r = ar[31:0];
                c = ar[33];
                v = ar[32];
            end
            e.res = r;
            e.we  = (op[3:2] != 2'b10);
            if (s || op[3:2] == 2'b10) m_flags = {r[31], (r == 32'b0), c, v};
        end
        e.nzcv = m_flags;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic shc, input logic s, input logic mul);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: in_ready got 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        alu_op = op; srca = a; srcb = b; sh_carry = shc; set_flags = s; is_mul = mul;
        in_valid = 1'b1;
        predict(op, a, b, shc, s, mul);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_valid: got result %h, expected no output", result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", result, mon_e.res);
                chk("wr_en", 32'(wr_en), 32'(mon_e.we));
                chk("flags", 32'(flags), 32'(mon_e.nzcv));
                chk("latency", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, guard, nv;
        reset = 1'b1; in_valid = 1'b0; srca = '0; srcb = '0; sh_carry = 1'b0;
        alu_op = '0; is_mul = 1'b0; set_flags = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        issue(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
        idle(2);
        issue(4'hA, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
        issue(4'h5, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        idle(1);
        issue(4'h2, 32'd10, 32'd3, 1'b0, 1'b1, 1'b0);
        issue(4'h2, 32'd3, 32'd10, 1'b0, 1'b1, 1'b0);
        issue(4'h2, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        issue(4'h2, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0);
        issue(4'hD, 32'h1234_5678, 32'd0, 1'b1, 1'b1, 1'b0);
        idle(2);

        issue(4'h0, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1, 1'b1);
        nb = 0;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && guard < 100) begin
            if (busy && !in_ready) nb++;
            @(negedge clk);
            guard++;
        end
`ifdef EXEC_ALU_MUL_EN
        chk("mul_busy_cycles", nb, 32'd32);
`else
        chk("mul_busy_cycles", nb, 32'd0);
`endif
        idle(2);

        issue(4'h0, 32'h0001_0001, 32'h0000_0007, 1'b0, 1'b1, 1'b1);
        idle(10);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        sb_q.delete();
        m_flags = 4'b0000;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("abort_no_valid", nv, 32'd0);

        for (int i = 0; i < 160; i++) begin
            issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);

        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_outstanding", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
